mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the bus widths and the arbiter state encoding so that the
// arbiter and any neighbouring blocks agree on them.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SEL_W  = 4;

    // Instruction fetches always read the whole word.
    localparam logic [SEL_W-1:0] SEL_WORD = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_IF_DROP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the fetch stage and the MEM stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req, if_addr          fetch request (held until if_ready)
//   mem_req, mem_we,
//   mem_addr, mem_wdata,
//   mem_sel                  load/store request (held until mem_ready)
//   flush                    branch redirect: the fetch in flight is stale
//   ram_ce, ram_we, ram_addr,
//   ram_wdata, ram_sel       RAM command, held stable until ram_ack
//   ram_rdata, ram_ack       RAM read data and completion pulse
//   if_rdata, mem_rdata      registered read data
//   if_ready, mem_ready      one-cycle completion pulses
//   stallreq_if/_mem         stall requests to the pipeline controller
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic              flush,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [SEL_W-1:0]  ram_sel,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_ready,
    output logic              mem_ready,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        we_d        = we_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A requester still holding its request during its own ready
                // pulse is not re-granted; this is the idle gap after completion.
                if (mem_req && !mem_ready_q) begin
                    state_d = ST_MEM_WAIT;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    sel_d   = mem_sel;
                    we_d    = mem_we;
                end else if (if_req && !flush && !if_ready_q) begin
                    state_d = ST_IF_WAIT;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    sel_d   = SEL_WORD;
                    we_d    = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                if (ram_ack) begin
                    state_d     = ST_IDLE;
                    mem_ready_d = 1'b1;
                    if (!we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                end
            end
            ST_IF_WAIT: begin
                if (ram_ack) begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        if_rdata_d = ram_rdata;
                        if_ready_d = 1'b1;
                    end
                end else if (flush) begin
                    state_d = ST_IF_DROP;
                end
            end
            ST_IF_DROP: begin
                // Let the stale access finish on the RAM, then discard it.
                if (ram_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        ram_ce       = (state_q != ST_IDLE);
        ram_we       = (state_q == ST_MEM_WAIT) && we_q;
        ram_addr     = addr_q;
        ram_wdata    = wdata_q;
        ram_sel      = sel_q;
        if_rdata     = if_rdata_q;
        mem_rdata    = mem_rdata_q;
        if_ready     = if_ready_q;
        mem_ready    = mem_ready_q;
        stallreq_if  = if_req && !if_ready_q;
        stallreq_mem = mem_req && !mem_ready_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        flush;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_sel;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        if_ready;
    logic        mem_ready;
    logic        stallreq_if;
    logic        stallreq_mem;

    int checks = 0;
    int errors = 0;

    logic [31:0] ifq[$];
    logic [31:0] memq[$];
    logic [31:0] if_model  = '0;
    logic [31:0] mem_model = '0;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int unsigned delay;
        logic [31:0] rdata;
        logic        flush_w;
        logic        exp_we;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[7];

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_sel      (mem_sel),
        .flush        (flush),
        .ram_ce       (ram_ce),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_sel      (ram_sel),
        .ram_rdata    (ram_rdata),
        .ram_ack      (ram_ack),
        .if_rdata     (if_rdata),
        .mem_rdata    (mem_rdata),
        .if_ready     (if_ready),
        .mem_ready    (mem_ready),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every ready pulse pops one expected read-data value.
    always @(negedge clk) begin
        if (if_ready && mem_ready)
            chk1("ready_exclusive", 1'b1, 1'b0);
        if (mem_ready) begin
            if (memq.size() == 0) chk1("mem_ready_unexpected", mem_ready, 1'b0);
            else                  chk32("mem_rdata", mem_rdata, memq.pop_front());
        end
        if (if_ready) begin
            if (ifq.size() == 0) chk1("if_ready_unexpected", if_ready, 1'b0);
            else                 chk32("if_rdata", if_rdata, ifq.pop_front());
        end
    end

    task automatic run_txn(input vec_t v);
        if (v.is_mem) begin
            if (!v.we) mem_model = v.rdata;
            memq.push_back(mem_model);
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
            mem_wdata = v.wdata; mem_sel = v.sel;
        end else begin
            if_model = v.rdata;
            ifq.push_back(v.rdata);
            if_req = 1'b1; if_addr = v.addr;
        end
        step();
        chk1("grant_ce", ram_ce, 1'b1);
        for (int unsigned c = 0; c <= v.delay; c++) begin
            chk32("ram_addr", ram_addr, v.addr);
            chk1("ram_we", ram_we, v.exp_we);
            chk32("ram_sel", {28'h0, ram_sel}, {28'h0, v.exp_sel});
            if (v.is_mem && v.we) chk32("ram_wdata", ram_wdata, v.wdata);
            chk1("stallreq", v.is_mem ? stallreq_mem : stallreq_if, 1'b1);
            flush = v.flush_w;
            if (c == v.delay) begin
                ram_ack = 1'b1; ram_rdata = v.rdata;
            end else begin
                ram_rdata = $urandom;
            end
            step();
        end
        ram_ack = 1'b0; flush = 1'b0; ram_rdata = $urandom;
        chk1("ready_pulse", v.is_mem ? mem_ready : if_ready, 1'b1);
        chk1("ce_after_ack", ram_ce, 1'b0);
        chk1("stall_released", v.is_mem ? stallreq_mem : stallreq_if, 1'b0);
        step();
        mem_req = 1'b0; if_req = 1'b0;
        chk1("no_regrant", ram_ce, 1'b0);
        chk1("ready_single", v.is_mem ? mem_ready : if_ready, 1'b0);
    endtask

    initial begin
        //          mem   we    addr           wdata          sel   dly rdata          flsh  exp_we exp_sel
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 3, 32'h1234_5678, 1'b0, 1'b0, 4'hF};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 0, 32'h1111_2222, 1'b0, 1'b0, 4'hF};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'h3, 2, 32'h5555_AAAA, 1'b1, 1'b1, 4'h3};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 32'h0000_0013, 1'b0, 1'b0, 4'hF};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4'h5, 1, 32'hA5A5_5A5A, 1'b1, 1'b0, 4'h5};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0300, 32'h0102_0304, 4'hC, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'hC};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 4, 32'h8000_0001, 1'b0, 1'b0, 4'hF};

        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_sel = '0; flush = 1'b0;
        ram_rdata = '0; ram_ack = 1'b0;
        step();
        step();
        chk1("rst_ce", ram_ce, 1'b0);
        chk1("rst_we", ram_we, 1'b0);
        chk32("rst_addr", ram_addr, 32'h0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_txn(vecs[i]);

        // ram_ack while idle is ignored
        ram_ack = 1'b1; ram_rdata = 32'hBADB_AD00;
        step();
        ram_ack = 1'b0;
        chk1("idle_ack_ce", ram_ce, 1'b0);
        chk1("idle_ack_if_ready", if_ready, 1'b0);
        chk1("idle_ack_mem_ready", mem_ready, 1'b0);

        // flush in IDLE blocks a fetch grant
        if_req = 1'b1; if_addr = 32'h0000_0060; flush = 1'b1;
        step();
        chk1("idle_flush_blocks", ram_ce, 1'b0);
        if_req = 1'b0; flush = 1'b0;
        step();

        // collision: MEM wins, one idle cycle, then fetch
        mem_model = 32'hCAFE_0001; memq.push_back(mem_model);
        if_model  = 32'h0A0B_0C0D; ifq.push_back(if_model);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0100; mem_sel = 4'hF;
        if_req = 1'b1; if_addr = 32'h0000_0050;
        step();
        chk1("col_ce", ram_ce, 1'b1);
        chk32("col_mem_first", ram_addr, 32'h0000_0100);
        chk1("col_stall_if", stallreq_if, 1'b1);
        ram_ack = 1'b1; ram_rdata = 32'hCAFE_0001;
        step();
        ram_ack = 1'b0;
        chk1("col_mem_ready", mem_ready, 1'b1);
        chk1("col_idle_gap", ram_ce, 1'b0);
        step();
        mem_req = 1'b0;
        chk1("col_if_ce", ram_ce, 1'b1);
        chk32("col_if_addr", ram_addr, 32'h0000_0050);
        chk32("col_if_sel", {28'h0, ram_sel}, 32'hF);
        ram_ack = 1'b1; ram_rdata = 32'h0A0B_0C0D;
        step();
        ram_ack = 1'b0;
        chk1("col_if_ready", if_ready, 1'b1);
        step();
        if_req = 1'b0;
        step();

        // flush in IF_WAIT, ack two cycles later
        if_req = 1'b1; if_addr = 32'h0000_0020;
        step();
        chk1("fl_ce", ram_ce, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0; if_req = 1'b0;
        chk1("fl_drop_ce", ram_ce, 1'b1);
        chk32("fl_drop_addr", ram_addr, 32'h0000_0020);
        step();
        chk1("fl_drop_hold", ram_ce, 1'b1);
        ram_ack = 1'b1; ram_rdata = 32'hDEAD_0020;
        step();
        ram_ack = 1'b0;
        chk1("fl_no_ready", if_ready, 1'b0);
        chk1("fl_idle", ram_ce, 1'b0);
        chk32("fl_rdata_kept", if_rdata, if_model);
        step();

        // flush and ack together in IF_WAIT, then a normal fetch
        if_req = 1'b1; if_addr = 32'h0000_0040;
        step();
        flush = 1'b1; ram_ack = 1'b1; ram_rdata = 32'hBAD0_0040;
        step();
        flush = 1'b0; ram_ack = 1'b0;
        chk1("fa_no_ready", if_ready, 1'b0);
        chk1("fa_idle", ram_ce, 1'b0);
        chk32("fa_rdata_kept", if_rdata, if_model);
        run_txn('{1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 32'h7777_0044, 1'b0, 1'b0, 4'hF});

        // reset in MEM_WAIT, late ack ignored
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0400;
        mem_wdata = 32'h1357_9BDF; mem_sel = 4'hF;
        step();
        chk1("rm_ce", ram_ce, 1'b1);
        chk1("rm_we", ram_we, 1'b1);
        rst = 1'b1; mem_req = 1'b0;
        step();
        rst = 1'b0;
        ram_ack = 1'b1; ram_rdata = 32'h2468_ACE0;
        step();
        ram_ack = 1'b0;
        chk1("rm_ce_clr", ram_ce, 1'b0);
        chk1("rm_we_clr", ram_we, 1'b0);
        chk1("rm_no_ready", mem_ready, 1'b0);
        chk32("rm_addr_clr", ram_addr, 32'h0);
        chk32("rm_wdata_clr", ram_wdata, 32'h0);
        chk32("rm_sel_clr", {28'h0, ram_sel}, 32'h0);
        chk32("rm_if_rdata_clr", if_rdata, 32'h0);
        chk32("rm_mem_rdata_clr", mem_rdata, 32'h0);
        step();
        chk1("rm_still_idle", ram_ce, 1'b0);

        chk32("ifq_drained", 32'(ifq.size()), 32'h0);
        chk32("memq_drained", 32'(memq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
